weight_tile_loader: RTL

WEIGHT_TILE_LOADER -- requirements
Module: weight_tile_loader

---
 rtl/weight_pkg.sv | 19 +
 rtl/weight_tile_assembler.sv | 55 +++++
 rtl/weight_tile_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/weight_pkg.sv
// Shared types and sizes for the weight tile loader.
// Tile type and loader FSM states.
package weight_pkg;

  localparam int ELEM_W = 12;
  localparam int TILE   = 6;
  localparam int TILE_N = TILE * TILE;
  localparam int PAIR_N = 2 * TILE_N;

  typedef logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/weight_tile_assembler.sv
// Builds one TILE x TILE weight tile, one element per write.
// Linear index maps row-major onto the tile register.
module weight_tile_assembler #(
  parameter int ELEM_W = weight_pkg::ELEM_W,
  parameter int TILE   = weight_pkg::TILE
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       we_i,
  input  logic [$clog2(TILE*TILE)-1:0]               idx_i,
  input  logic signed [ELEM_W-1:0]                   data_i,
  output logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] tile_o
);

  import weight_pkg::*;

  localparam int IDX_W = $clog2(TILE * TILE);

  logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] tile_q;
  logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] tile_d;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;

  // Split the linear index into row and column.
  always_comb begin
    row = idx_i / IDX_W'(TILE);
    col = idx_i % IDX_W'(TILE);
  end

  // Overwrite only the addressed element; all others hold.
  always_comb begin
    tile_d = tile_q;
    if (we_i) begin
      for (int r = 0; r < TILE; r++) begin
        for (int c = 0; c < TILE; c++) begin
          if (row == IDX_W'(r) && col == IDX_W'(c)) begin
            tile_d[r][c] = data_i;
          end
        end
      end
    end
  end

  // Tile storage, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_q <= '0;
    end else begin
      tile_q <= tile_d;
    end
  end

  assign tile_o = tile_q;

endmodule

// File: rtl/weight_tile_loader.sv
// Streams weight elements into tile pairs and writes
// each completed pair to weight memory in one cycle.
module weight_tile_loader #(
  parameter int ELEM_W = weight_pkg::ELEM_W,
  parameter int TILE   = weight_pkg::TILE
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start_i,
  input  logic [7:0]                                   num_pairs_i,
  input  logic [7:0]                                   base_addr_i,
  input  logic                                         in_valid_i,
  input  logic signed [ELEM_W-1:0]                     in_data_i,
  output logic                                         in_ready_o,
  output logic                                         mem_we_o,
  output logic [7:0]                                   mem_addr_o,
  output logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] mem_wdata_1_o,
  output logic signed [TILE-1:0][TILE-1:0][ELEM_W-1:0] mem_wdata_2_o,
  output logic                                         busy_o,
  output logic                                         done_o
);

  import weight_pkg::*;

  localparam int T_N   = TILE * TILE;
  localparam int P_N   = 2 * T_N;
  localparam int CNT_W = $clog2(P_N);
  localparam int IDX_W = $clog2(T_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pair_q, pair_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       base_q, base_d;

  logic             xfer;
  logic             sel_1;
  logic             we_1;
  logic             we_2;
  logic [IDX_W-1:0] idx_1;
  logic [IDX_W-1:0] idx_2;

  // Route each accepted element to the first or second tile.
  always_comb begin
    xfer  = (state_q == FILL) && in_valid_i;
    sel_1 = cnt_q < CNT_W'(T_N);
    we_1  = xfer && sel_1;
    we_2  = xfer && !sel_1;
    idx_1 = IDX_W'(cnt_q);
    idx_2 = IDX_W'(cnt_q - CNT_W'(T_N));
  end

  weight_tile_assembler #(
    .ELEM_W (ELEM_W),
    .TILE   (TILE)
  ) u_tile_1 (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we_1),
    .idx_i  (idx_1),
    .data_i (in_data_i),
    .tile_o (mem_wdata_1_o)
  );

  weight_tile_assembler #(
    .ELEM_W (ELEM_W),
    .TILE   (TILE)
  ) u_tile_2 (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we_2),
    .idx_i  (idx_2),
    .data_i (in_data_i),
    .tile_o (mem_wdata_2_o)
  );

  // Next state, job counters and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pair_d     = pair_q;
    num_d      = num_q;
    base_d     = base_q;
    in_ready_o = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 8'd0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          num_d   = num_pairs_i;
          base_d  = base_addr_i;
          pair_d  = 8'd0;
          cnt_d   = '0;
          state_d = (num_pairs_i != 8'd0) ? FILL : DONE;
        end
      end
      FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (cnt_q == CNT_W'(P_N - 1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        mem_we_o   = 1'b1;
        mem_addr_o = base_q + pair_q;
        if (pair_q == num_q - 8'd1) begin
          state_d = DONE;
        end else begin
          pair_d  = pair_q + 8'd1;
          state_d = FILL;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pair_q  <= 8'd0;
      num_q   <= 8'd0;
      base_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      num_q   <= num_d;
      base_q  <= base_d;
    end
  end

endmodule
